pkt_rx_tm: RTL and testbench

Receive-side packet manager for the 8-channel inter-board link. It accepts LocalLink frames from the SerDes receive core, strips the 1-word header, and writes the payload into the addressed channel's 2K×16 packet RAM. Each good frame gets a 24-bit descriptor in that channel's info FIFO, in the same format the transmit-side packet manager consumes. Bad frames are dropped and counted, and their RAM space is reclaimed.

---
 rtl/pkt_rx_tm.sv | 173 +++++++++++++++++
 tb/tb_pkt_rx_tm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rx_tm.sv
// Receive-side packet manager: LocalLink frames -> per-channel packet RAM + info FIFO.
// Define PKT_RX_LEN_CHK_EN to drop frames whose payload count differs from the header length.
module pkt_rx_tm #(
    parameter int CHAN_NUMS = 8,
    parameter int RAM_DEPTH = 11,
    parameter int MAX_LEN   = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [0:15]          rx_data,
    input  logic                 rx_rem,
    input  logic                 rx_sof_n,
    input  logic                 rx_eof_n,
    input  logic                 rx_src_rdy_n,
    output logic                 rx_dst_rdy_n,
    output logic [CHAN_NUMS-1:0] ram_wen,
    output logic [RAM_DEPTH-1:0] ram_waddr,
    output logic [15:0]          ram_din,
    output logic [CHAN_NUMS-1:0] info_wen,
    output logic [23:0]          info_din,
    input  logic [CHAN_NUMS-1:0] info_full,
    input  logic [CHAN_NUMS-1:0] ram_afull,
    output logic [15:0]          drop_cnt
);

    localparam int CW = $clog2(CHAN_NUMS);
    localparam int LW = 10;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DROP, ST_COMMIT} state_t;

    state_t               state;
    logic [CW-1:0]        cur_ch;
    logic [RAM_DEPTH-1:0] start;
    logic [LW-1:0]        wcnt;
    logic [RAM_DEPTH-1:0] wptr [CHAN_NUMS];

    logic                 acc;
    logic                 sof;
    logic                 eof;
    logic [CW-1:0]        hdr_ch;
    logic                 hdr_bad;
    logic                 hdr_drop;
    logic                 hdr_take;
    state_t               hdr_state;
    logic                 at_max;
    logic                 len_bad;
    logic [RAM_DEPTH-1:0] addr_now;
    logic [CHAN_NUMS-1:0] ch_sel;
    logic [1:0]           ndrop;
    logic [16:0]          drop_sum;
    logic [15:0]          drop_next;
    logic                 unused;

    assign unused   = rx_rem;
    assign acc      = !rx_src_rdy_n && !rx_dst_rdy_n;
    assign sof      = !rx_sof_n;
    assign eof      = !rx_eof_n;
    assign hdr_ch   = rx_data[16-CW:15];
    assign hdr_bad  = info_full[hdr_ch] | ram_afull[hdr_ch];
    assign hdr_drop = eof | hdr_bad;
    assign hdr_take = acc && sof && (state == ST_IDLE || state == ST_DATA);
    assign at_max   = (wcnt == LW'(MAX_LEN));
    assign addr_now = start + RAM_DEPTH'(wcnt);
    assign ch_sel   = CHAN_NUMS'(1) << cur_ch;

`ifdef PKT_RX_LEN_CHK_EN
    logic [LW-1:0] hdr_len;
    logic [LW-1:0] exp_len;
    assign hdr_len = rx_data[3:12];
    // The EOF beat is still being counted, so compare against wcnt+1.
    assign len_bad = (wcnt + 1'b1) != exp_len;
`else
    assign len_bad = 1'b0;
`endif

    always_comb begin
        hdr_state = ST_DATA;
        if (eof)
            hdr_state = ST_IDLE;
        else if (hdr_bad)
            hdr_state = ST_DROP;
    end

    // A SOF inside a frame can drop the old frame and its own header at once.
    always_comb begin
        ndrop = 2'd0;
        if (acc) begin
            unique case (state)
                ST_IDLE: if (sof) ndrop = {1'b0, hdr_drop};
                ST_DATA: begin
                    if (sof)
                        ndrop = 2'd1 + {1'b0, hdr_drop};
                    else if (at_max || (eof && len_bad))
                        ndrop = 2'd1;
                end
                default: ndrop = 2'd0;
            endcase
        end
    end

    assign drop_sum  = {1'b0, drop_cnt} + 17'(ndrop);
    assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rx_dst_rdy_n <= 1'b0;
            ram_wen      <= '0;
            ram_waddr    <= '0;
            ram_din      <= '0;
            info_wen     <= '0;
            info_din     <= '0;
            drop_cnt     <= '0;
            cur_ch       <= '0;
            start        <= '0;
            wcnt         <= '0;
`ifdef PKT_RX_LEN_CHK_EN
            exp_len      <= '0;
`endif
            for (int i = 0; i < CHAN_NUMS; i++)
                wptr[i] <= '0;
        end else begin
            ram_wen  <= '0;
            info_wen <= '0;
            drop_cnt <= drop_next;
            if (hdr_take) begin
                cur_ch <= hdr_ch;
                start  <= wptr[hdr_ch];
                wcnt   <= '0;
                state  <= hdr_state;
`ifdef PKT_RX_LEN_CHK_EN
                exp_len <= hdr_len;
`endif
            end else begin
                unique case (state)
                    ST_IDLE: ;
                    ST_DATA: begin
                        if (acc) begin
                            if (at_max) begin
                                state <= eof ? ST_IDLE : ST_DROP;
                            end else begin
                                ram_wen   <= ch_sel;
                                ram_waddr <= addr_now;
                                ram_din   <= rx_data;
                                wcnt      <= wcnt + 1'b1;
                                if (eof) begin
                                    if (len_bad) begin
                                        state <= ST_IDLE;
                                    end else begin
                                        state        <= ST_COMMIT;
                                        rx_dst_rdy_n <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    ST_DROP: begin
                        if (acc && eof)
                            state <= ST_IDLE;
                    end
                    ST_COMMIT: begin
                        info_wen     <= ch_sel;
                        info_din     <= {cur_ch, wcnt, start};
                        wptr[cur_ch] <= addr_now;
                        state        <= ST_IDLE;
                        rx_dst_rdy_n <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pkt_rx_tm.sv
// Scoreboard bench for pkt_rx_tm: frame-level reference model, queue-based monitor.
module tb_pkt_rx_tm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:15] rx_data;
    logic        rx_rem;
    logic        rx_sof_n;
    logic        rx_eof_n;
    logic        rx_src_rdy_n;
    logic        rx_dst_rdy_n;
    logic [7:0]  ram_wen;
    logic [10:0] ram_waddr;
    logic [15:0] ram_din;
    logic [7:0]  info_wen;
    logic [23:0] info_din;
    logic [7:0]  info_full;
    logic [7:0]  ram_afull;
    logic [15:0] drop_cnt;

    pkt_rx_tm dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rem(rx_rem),
        .rx_sof_n(rx_sof_n), .rx_eof_n(rx_eof_n),
        .rx_src_rdy_n(rx_src_rdy_n), .rx_dst_rdy_n(rx_dst_rdy_n),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_din(ram_din),
        .info_wen(info_wen), .info_din(info_din),
        .info_full(info_full), .ram_afull(ram_afull), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int last_stall = 0;
    int hdr_stall = 0;

    logic [34:0] exp_ram[$];
    logic [31:0] exp_info[$];
    int m_wptr[8];
    int m_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ram_wen != 0) begin
                if (exp_ram.size() == 0)
                    chk("ram_unexpected", {ram_wen, ram_waddr, ram_din}, 64'd0);
                else
                    chk("ram_write", {ram_wen, ram_waddr, ram_din}, exp_ram.pop_front());
            end
            if (info_wen != 0) begin
                if (exp_info.size() == 0)
                    chk("info_unexpected", {info_wen, info_din}, 64'd0);
                else
                    chk("descriptor", {info_wen, info_din}, exp_info.pop_front());
            end
        end
    end

    task automatic beat(input logic [15:0] d, input bit s, input bit e);
        int g = 0;
        rx_data = d;
        rx_sof_n = !s;
        rx_eof_n = !e;
        rx_src_rdy_n = 1'b0;
        while (rx_dst_rdy_n && g < 16) begin
            @(negedge clk);
            g++;
        end
        if (g >= 16) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: got stall %0d required < 16", g);
        end
        last_stall = g;
        @(negedge clk);
        rx_src_rdy_n = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_src_rdy_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Frame-level model: n payload words, intr = cut short by the next SOF.
    task automatic send_frame(input int ch, input int n, input int decl,
                              input bit bad, input bit intr, input int gap);
        logic [15:0] w[$];
        logic [15:0] h;
        int st;
        bit lchk;
`ifdef PKT_RX_LEN_CHK_EN
        lchk = 1'b1;
`else
        lchk = 1'b0;
`endif
        for (int i = 0; i < n; i++) w.push_back(16'($urandom));
        st = m_wptr[ch];
        if (n == 0 || bad) begin
            m_drop++;
        end else begin
            for (int i = 0; i < n && i < 1023; i++)
                exp_ram.push_back({8'(1 << ch), 11'((st + i) % 2048), w[i]});
            if (intr || n > 1023 || (lchk && n != decl)) begin
                m_drop++;
            end else begin
                exp_info.push_back({8'(1 << ch), 3'(ch), 10'(n), 11'(st)});
                m_wptr[ch] = (st + n) % 2048;
            end
        end
        info_full = 8'($urandom);
        ram_afull = 8'($urandom);
        info_full[ch] = 1'b0;
        ram_afull[ch] = 1'b0;
        if (bad) begin
            if ($urandom_range(1, 0) == 1) info_full[ch] = 1'b1;
            else ram_afull[ch] = 1'b1;
        end
        h = {3'b0, 10'(decl), 3'(ch)};
        beat(h, 1'b1, n == 0);
        hdr_stall = last_stall;
        for (int i = 0; i < n; i++) begin
            info_full = 8'($urandom);
            ram_afull = 8'($urandom);
            beat(w[i], 1'b0, !intr && i == n - 1);
        end
        if (gap > 0) idle(gap);
    endtask

    initial begin
        bit lchk;
`ifdef PKT_RX_LEN_CHK_EN
        lchk = 1'b1;
`else
        lchk = 1'b0;
`endif
        for (int i = 0; i < 8; i++) m_wptr[i] = 0;
        rst_n = 1'b0;
        rx_data = '0;
        rx_rem = 1'b0;
        rx_sof_n = 1'b1;
        rx_eof_n = 1'b1;
        rx_src_rdy_n = 1'b1;
        info_full = '0;
        ram_afull = '0;
        repeat (3) @(negedge clk);
        chk("rst_dst_rdy_n", rx_dst_rdy_n, 0);
        chk("rst_ram_wen", ram_wen, 0);
        chk("rst_info_wen", info_wen, 0);
        chk("rst_ram_waddr", ram_waddr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_info_din", info_din, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        idle(2);

        send_frame(2, 4, 4, 0, 0, 3);
        chk("plan1_last_desc", info_din, 24'h402000);
        send_frame(2, 2, 2, 0, 0, 2);

        send_frame(5, 3, 3, 0, 0, 0);
        chk("b2b_rdy_high_1", rx_dst_rdy_n, 1);
        send_frame(5, 2, 2, 0, 0, 0);
        chk("b2b_stall", hdr_stall, 1);
        chk("b2b_rdy_high_2", rx_dst_rdy_n, 1);
        idle(1);
        chk("b2b_rdy_low", rx_dst_rdy_n, 0);
        idle(2);

        send_frame(1, 1023, 1023, 0, 0, 0);
        send_frame(1, 1023, 1023, 0, 0, 0);
        send_frame(1, 4, 4, 0, 0, 3);
        chk("wrap_desc", info_din, {3'd1, 10'd4, 11'd2046});

        send_frame(3, 10, 10, 1, 0, 3);
        chk("full_drop", drop_cnt, m_drop);

        send_frame(0, 2, 2, 0, 1, 0);
        send_frame(6, 1, 1, 0, 0, 3);
        chk("midsof_drop", drop_cnt, m_drop);

        send_frame(7, 4, 5, 0, 0, 3);
        chk("lenchk_drop", drop_cnt, m_drop);
        if (!lchk) chk("lenchk_desc", info_din, {3'd7, 10'd4, 11'd0});

        send_frame(4, 0, 0, 0, 0, 2);
        send_frame(0, 1025, 1025, 0, 0, 3);
        send_frame(0, 3, 3, 0, 0, 3);
        chk("boundary_drop", drop_cnt, m_drop);

        send_frame(4, 2, 2, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ram_wen", ram_wen, 0);
        chk("arst_waddr", ram_waddr, 0);
        chk("arst_drop", drop_cnt, 0);
        chk("arst_rdy", rx_dst_rdy_n, 0);
        for (int i = 0; i < 8; i++) m_wptr[i] = 0;
        m_drop = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        beat(16'h1234, 1'b0, 1'b0);
        beat(16'h5678, 1'b0, 1'b1);
        idle(2);
        send_frame(4, 3, 3, 0, 0, 3);
        chk("post_rst_drop", drop_cnt, 0);

        for (int k = 0; k < 150; k++) begin
            int ch, n, decl, gap;
            bit bad, intr;
            ch = $urandom_range(7, 0);
            n = $urandom_range(40, 0);
            bad = ($urandom_range(7, 0) == 0);
            decl = ($urandom_range(7, 0) == 0) ? $urandom_range(40, 0) : n;
            intr = !bad && n > 0 && k != 149 && ($urandom_range(7, 0) == 0);
            gap = intr ? 0 : $urandom_range(3, 0);
            send_frame(ch, n, decl, bad, intr, gap);
        end
        idle(10);
        chk("final_drop", drop_cnt, m_drop);
        chk("ram_queue_empty", exp_ram.size(), 0);
        chk("info_queue_empty", exp_info.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
